// File: rtl/fft_host_sequencer.sv
// Host-side initiator for the FFT engine pin protocol: loads one frame of packed
// samples, pulses start, waits out the compute window, then reads results back.
module fft_host_sequencer #(
  parameter int N_PTS          = 4,
  parameter int DW             = 8,
  parameter int COMPUTE_CYCLES = 4,
  parameter int READ_LAT       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [N_PTS*DW-1:0] cmd_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N_PTS*DW-1:0] res_data,
  output logic                busy,
  output logic [DW-1:0]       eng_ui_in,
  output logic [7:0]          eng_uio_in,
  input  logic [DW-1:0]       eng_uo_out
);

  localparam int AW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam int CW = $clog2(COMPUTE_CYCLES + READ_LAT + 2);

  localparam logic [AW-1:0] PT_LAST   = AW'(N_PTS - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(COMPUTE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [AW-1:0]       pt_q;
  logic [AW-1:0]       pt_nx;
  logic [CW-1:0]       cyc_q;
  logic [N_PTS*DW-1:0] frame_q;

  // Control byte layout on uio_in: load, start, rd strobes then the point address.
  function automatic logic [7:0] pins(input logic ld, input logic st,
                                      input logic rd, input logic [AW-1:0] addr);
    logic [7:0] u;
    u          = '0;
    u[0]       = ld;
    u[1]       = st;
    u[2]       = rd;
    u[3 +: AW] = addr;
    return u;
  endfunction

  assign pt_nx = pt_q + 1'b1;

  // Frame latch is pure data; only written on accept so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cmd_valid && cmd_ready) begin
      frame_q <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pt_q       <= '0;
      cyc_q      <= '0;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      res_data   <= '0;
      eng_ui_in  <= '0;
      eng_uio_in <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // Point 0 goes straight from the bus so it is on the pins in the first LOAD cycle.
            state_q    <= S_LOAD;
            pt_q       <= '0;
            cyc_q      <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            eng_ui_in  <= cmd_data[DW-1:0];
            eng_uio_in <= pins(1'b1, 1'b0, 1'b0, '0);
          end
        end

        S_LOAD: begin
          if (pt_q == PT_LAST) begin
            state_q    <= S_START;
            pt_q       <= '0;
            cyc_q      <= '0;
            eng_ui_in  <= '0;
            eng_uio_in <= pins(1'b0, 1'b1, 1'b0, '0);
          end else begin
            pt_q       <= pt_nx;
            eng_ui_in  <= frame_q[int'(pt_nx)*DW +: DW];
            eng_uio_in <= pins(1'b1, 1'b0, 1'b0, pt_nx);
          end
        end

        S_START: begin
          state_q    <= S_WAIT;
          pt_q       <= '0;
          cyc_q      <= '0;
          eng_uio_in <= '0;
        end

        S_WAIT: begin
          if (cyc_q == WAIT_LAST) begin
            state_q    <= S_READ;
            pt_q       <= '0;
            cyc_q      <= '0;
            eng_uio_in <= pins(1'b0, 1'b0, 1'b1, '0);
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        S_READ: begin
          if (cyc_q == RD_LAST) begin
            // Last cycle of this point: engine output is valid now.
            res_data[int'(pt_q)*DW +: DW] <= eng_uo_out;
            cyc_q <= '0;
            if (pt_q == PT_LAST) begin
              state_q    <= S_DONE;
              pt_q       <= '0;
              res_valid  <= 1'b1;
              eng_uio_in <= '0;
            end else begin
              pt_q       <= pt_nx;
              eng_uio_in <= pins(1'b0, 1'b0, 1'b1, pt_nx);
            end
          end else begin
            cyc_q      <= cyc_q + 1'b1;
            eng_uio_in <= pins(1'b0, 1'b0, 1'b0, pt_q);
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state_q   <= S_IDLE;
            pt_q      <= '0;
            cyc_q     <= '0;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          pt_q       <= '0;
          cyc_q      <= '0;
          cmd_ready  <= 1'b1;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
          eng_ui_in  <= '0;
          eng_uio_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_host_sequencer.sv
// Directed bench for fft_host_sequencer with a one-cycle-latency engine read model.
module tb_fft_host_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [N*DW-1:0] cmd_data = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [N*DW-1:0] res_data;
  logic            busy;
  logic [DW-1:0]   eng_ui_in;
  logic [7:0]      eng_uio_in;
  logic [DW-1:0]   eng_uo_out;

  logic [7:0] eng_base = 8'hA0;
  logic [7:0] eng_q    = 8'h00;

  int errors = 0;
  int checks = 0;
  bit mon_en  = 1'b0;
  bit rv_seen = 1'b0;

  always #5 clk = ~clk;

  fft_host_sequencer #(.N_PTS(N), .DW(DW), .COMPUTE_CYCLES(4), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .eng_ui_in(eng_ui_in), .eng_uio_in(eng_uio_in), .eng_uo_out(eng_uo_out)
  );

  // Engine read port: result for addr appears one clock after the rd strobe.
  always @(posedge clk) begin
    if (eng_uio_in[2]) eng_q <= eng_base + {6'd0, eng_uio_in[4:3]};
  end
  assign eng_uo_out = eng_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("ctrl_onehot", 64'($countones(eng_uio_in[2:0]) <= 1), 64'd1);
      chk("uio_unused", 64'(eng_uio_in[7:5]), 64'd0);
    end
    if (res_valid) rv_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a frame and returns just after its accept edge.
  task automatic send(input logic [N*DW-1:0] d);
    int n;
    n = 0;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("send_ready_timeout", 64'd0, 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_data  = ~d;
  endtask

  task automatic wait_rv(output int edges);
    edges = 0;
    while (!res_valid && edges < 40) begin
      step();
      edges++;
    end
  endtask

  typedef struct {
    logic [7:0] uio;
    logic [7:0] ui;
    logic       rv;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int e;
    logic [7:0] b;

    // Index = clock edges since accept.
    tbl[0]  = '{8'h01, 8'h11, 1'b0};
    tbl[1]  = '{8'h09, 8'h22, 1'b0};
    tbl[2]  = '{8'h11, 8'h33, 1'b0};
    tbl[3]  = '{8'h19, 8'h44, 1'b0};
    tbl[4]  = '{8'h02, 8'h00, 1'b0};
    tbl[5]  = '{8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h00, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h04, 8'h00, 1'b0};
    tbl[10] = '{8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'h0C, 8'h00, 1'b0};
    tbl[12] = '{8'h08, 8'h00, 1'b0};
    tbl[13] = '{8'h14, 8'h00, 1'b0};
    tbl[14] = '{8'h10, 8'h00, 1'b0};
    tbl[15] = '{8'h1C, 8'h00, 1'b0};
    tbl[16] = '{8'h18, 8'h00, 1'b0};
    tbl[17] = '{8'h00, 8'h00, 1'b1};

    // Reset state
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_ui", 64'(eng_ui_in), 64'd0);
    chk("rst_uio", 64'(eng_uio_in), 64'd0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Frame 1: load pattern, compute window, readback, latency
    send(32'h44332211);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      chk($sformatf("t1_uio[%0d]", i), 64'(eng_uio_in), 64'(tbl[i].uio));
      chk($sformatf("t1_ui[%0d]", i), 64'(eng_ui_in), 64'(tbl[i].ui));
      chk($sformatf("t1_rv[%0d]", i), 64'(res_valid), 64'(tbl[i].rv));
      chk($sformatf("t1_busy[%0d]", i), 64'(busy), 64'd1);
    end
    chk("t2_res_data", 64'(res_data), 64'hA3A2A1A0);

    // Backpressure in DONE; a new command must be ignored meanwhile
    cmd_valid = 1'b1;
    cmd_data  = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_rv", 64'(res_valid), 64'd1);
      chk("t3_hold_data", 64'(res_data), 64'hA3A2A1A0);
      chk("t3_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t3_rel_rv", 64'(res_valid), 64'd0);
    chk("t3_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t3_rel_busy", 64'(busy), 64'd0);
    chk("t3_rel_data_kept", 64'(res_data), 64'hA3A2A1A0);

    // cmd_valid pulse during WAIT is ignored
    eng_base = 8'hB0;
    send(32'h88776655);
    chk("t4_first_ui", 64'(eng_ui_in), 64'h55);
    chk("t4_first_uio", 64'(eng_uio_in), 64'h01);
    repeat (6) step();
    cmd_valid = 1'b1;
    cmd_data  = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_wait_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("t4_wait_uio", 64'(eng_uio_in), 64'd0);
      chk("t4_wait_ui", 64'(eng_ui_in), 64'd0);
    end
    cmd_valid = 1'b0;
    chk("t4_old_data_kept", 64'(res_data), 64'hA3A2A1A0);
    wait_rv(e);
    chk("t4_latency", 64'(e + 8), 64'd17);
    chk("t4_res_data", 64'(res_data), 64'hB3B2B1B0);
    cmd_valid = 1'b1;
    step();
    chk("t4_done_no_accept", 64'(cmd_ready), 64'd0);
    chk("t4_done_rv", 64'(res_valid), 64'd1);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t4_idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Reset during READ point 2
    eng_base = 8'hA0;
    send(32'h44332211);
    repeat (13) step();
    chk("t5_at_point2", 64'(eng_uio_in), 64'h14);
    rv_seen = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_uio", 64'(eng_uio_in), 64'd0);
    chk("t5_rst_ui", 64'(eng_ui_in), 64'd0);
    chk("t5_rst_rv", 64'(res_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_data", 64'(res_data), 64'd0);
    chk("t5_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("t5_no_rv", 64'(rv_seen), 64'd0);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    eng_base = 8'hC0;
    send(32'h0F0E0D0C);
    wait_rv(e);
    chk("t5_fresh_latency", 64'(e), 64'd17);
    chk("t5_fresh_data", 64'(res_data), 64'hC3C2C1C0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Back-to-back frames with res_ready held high
    res_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      b = 8'hD0 + 8'(f * 16);
      eng_base = b;
      send(32'h01020304 + 32'(f));
      wait_rv(e);
      chk($sformatf("t6_latency[%0d]", f), 64'(e), 64'd17);
      chk($sformatf("t6_data[%0d]", f), 64'(res_data),
          64'({b + 8'd3, b + 8'd2, b + 8'd1, b}));
      step();
      chk($sformatf("t6_idle_rdy[%0d]", f), 64'(cmd_ready), 64'd1);
      chk($sformatf("t6_idle_rv[%0d]", f), 64'(res_valid), 64'd0);
    end
    res_ready = 1'b0;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
